// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : opcode set, ALU Sigs encodings and opcode decode.
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;

  localparam int OP_W   = 3;
  localparam int SIGS_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_PADDSB = 3'b010,
    OP_NAND   = 3'b011,
    OP_XOR    = 3'b100
  } op_e;

  localparam logic [SIGS_W-1:0] SIGS_ADD    = 4'b0100;
  localparam logic [SIGS_W-1:0] SIGS_SUB    = 4'b0101;
  localparam logic [SIGS_W-1:0] SIGS_PADDSB = 4'b0110;
  localparam logic [SIGS_W-1:0] SIGS_NAND   = 4'b1000;
  localparam logic [SIGS_W-1:0] SIGS_XOR    = 4'b0000;
  localparam logic [SIGS_W-1:0] SIGS_IDLE   = 4'b0000;

  typedef struct packed {
    logic [SIGS_W-1:0] sigs;
    logic              illegal;
    logic              sets_nv;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
    op_dec_t d;
    d.sigs    = SIGS_IDLE;
    d.illegal = 1'b1;
    d.sets_nv = 1'b0;
    case (op)
      OP_ADD:    begin d.sigs = SIGS_ADD;    d.illegal = 1'b0; d.sets_nv = 1'b1; end
      OP_SUB:    begin d.sigs = SIGS_SUB;    d.illegal = 1'b0; d.sets_nv = 1'b1; end
      OP_PADDSB: begin d.sigs = SIGS_PADDSB; d.illegal = 1'b0; end
      OP_NAND:   begin d.sigs = SIGS_NAND;   d.illegal = 1'b0; end
      OP_XOR:    begin d.sigs = SIGS_XOR;    d.illegal = 1'b0; end
      default:   ;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : requester, ALU, response and flag signals of alu_arbiter.
// Rev 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int NB = 16
);

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [5:0]      req_op;
  logic [2*NB-1:0] req_a;
  logic [2*NB-1:0] req_b;
  logic [1:0]      req_flag_we;
  logic [NB-1:0]   alu_a;
  logic [NB-1:0]   alu_b;
  logic [3:0]      alu_sigs;
  logic [NB-1:0]   alu_out;
  logic            alu_v;
  logic            alu_n;
  logic            alu_z;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [NB-1:0]   resp_data;
  logic            resp_err;
  logic            flag_z;
  logic            flag_v;
  logic            flag_n;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_flag_we,
    input  alu_out, alu_v, alu_n, alu_z, resp_ready,
    output req_ready, alu_a, alu_b, alu_sigs,
    output resp_valid, resp_id, resp_data, resp_err,
    output flag_z, flag_v, flag_n
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_flag_we,
    output alu_out, alu_v, alu_n, alu_z, resp_ready,
    input  req_ready, alu_a, alu_b, alu_sigs,
    input  resp_valid, resp_id, resp_data, resp_err,
    input  flag_z, flag_v, flag_n
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin grant; ALU_ARB_FIXED_PRIO_EN selects strict
//           priority to requester 0 instead.  Rev 1.0
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic unused_arb_inputs;
  assign unused_arb_inputs = ^{clk, rst, accept};

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = ~req[0];
  end

`else

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid = |req;
    // On contention the requester that did not win last time goes first.
    if (&req) gnt_idx = ~last_grant_q;
    else      gnt_idx = req[1] & ~req[0];
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : shares one combinational ALU between two requesters, owns the
//               response register and Z/V/N flags (ALU_ARB_FIXED_PRIO_EN).
// Rev 1.0
// ============================================================================
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  logic          can_accept;
  logic          accept;
  logic          gnt_valid;
  logic          gnt_idx;
  logic          sel;
  logic [2:0]    sel_op;
  logic          sel_flag_we;
  op_dec_t       dec;

  logic          resp_valid_q, resp_valid_d;
  logic          resp_id_q,    resp_id_d;
  logic [NB-1:0] resp_data_q,  resp_data_d;
  logic          resp_err_q,   resp_err_d;
  logic          flag_z_q,     flag_z_d;
  logic          flag_v_q,     flag_v_d;
  logic          flag_n_q,     flag_n_d;

  assign can_accept = ~resp_valid_q | bus.resp_ready;
  assign accept     = gnt_valid & can_accept & ~rst;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // With no accepted grant the ALU sees requester 0 operands and idle sigs.
  always_comb begin
    sel           = accept & gnt_idx;
    sel_op        = sel ? bus.req_op[5:3] : bus.req_op[2:0];
    sel_flag_we   = sel ? bus.req_flag_we[1] : bus.req_flag_we[0];
    dec           = decode_op(sel_op);
    bus.req_ready = {accept & gnt_idx, accept & ~gnt_idx};
    bus.alu_a     = sel ? bus.req_a[2*NB-1:NB] : bus.req_a[NB-1:0];
    bus.alu_b     = sel ? bus.req_b[2*NB-1:NB] : bus.req_b[NB-1:0];
    bus.alu_sigs  = accept ? dec.sigs : SIGS_IDLE;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    flag_z_d     = flag_z_q;
    flag_v_d     = flag_v_q;
    flag_n_d     = flag_n_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_idx;
      resp_data_d  = dec.illegal ? '0 : bus.alu_out;
      resp_err_d   = dec.illegal;
      // N/V are only meaningful for the arithmetic ops; logic ops keep them.
      if (sel_flag_we && !dec.illegal) begin
        flag_z_d = bus.alu_z;
        if (dec.sets_nv) begin
          flag_n_d = bus.alu_n;
          flag_v_d = bus.alu_v;
        end
      end
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      flag_z_q     <= flag_z_d;
      flag_v_q     <= flag_v_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_v     = flag_v_q;
  assign bus.flag_n     = flag_n_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed and random checks of alu_arbiter against an
//                  opcode-level reference model.  Rev 1.0
// ============================================================================
module tb_alu_arbiter;

  localparam int NB = 16;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NB(NB)) ifc ();

  alu_arbiter #(.NB(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- arithmetic helpers ----------------
  function automatic logic [16:0] sat_addsub(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int ia, ib, s;
    ia = int'($signed(a));
    ib = int'($signed(b));
    s  = sub ? ia - ib : ia + ib;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      int s;
      s = int'($signed(a[8*k +: 8])) + int'($signed(b[8*k +: 8]));
      if (s > 127)       s = 127;
      else if (s < -128) s = -128;
      r[8*k +: 8] = s[7:0];
    end
    return r;
  endfunction

  // ---------------- ALU environment (driven by sigs) ----------------
  logic [16:0] alu_t;
  always_comb begin
    case (ifc.alu_sigs)
      4'b0100: alu_t = sat_addsub(ifc.alu_a, ifc.alu_b, 1'b0);
      4'b0101: alu_t = sat_addsub(ifc.alu_a, ifc.alu_b, 1'b1);
      4'b0110: alu_t = {ifc.alu_a[0], paddsb(ifc.alu_a, ifc.alu_b)};
      4'b1000: alu_t = {ifc.alu_a[0], ~(ifc.alu_a & ifc.alu_b)};
      default: alu_t = {ifc.alu_a[0], ifc.alu_a ^ ifc.alu_b};
    endcase
    ifc.alu_out = alu_t[15:0];
    ifc.alu_v   = alu_t[16];
    ifc.alu_n   = alu_t[15];
    ifc.alu_z   = (alu_t[15:0] == 16'h0000);
  end

  // ---------------- reference model (driven by opcode) ----------------
  // returns {illegal, overflow, data}
  function automatic logic [17:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return {1'b0, sat_addsub(a, b, 1'b0)};
      3'd1:    return {1'b0, sat_addsub(a, b, 1'b1)};
      3'd2:    return {2'b00, paddsb(a, b)};
      3'd3:    return {2'b00, ~(a & b)};
      3'd4:    return {2'b00, a ^ b};
      default: return {1'b1, 17'h0};
    endcase
  endfunction

  function automatic logic [3:0] exp_sigs(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b0100;
      3'd1:    return 4'b0101;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  logic        m_rv, m_id, m_err, m_z, m_v, m_n;
  logic [15:0] m_data;
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] o1, input logic [2:0] o0,
                       input logic [15:0] a1, input logic [15:0] a0,
                       input logic [15:0] b1, input logic [15:0] b0,
                       input logic [1:0] we, input logic rr);
    ifc.req_valid   = v;
    ifc.req_op      = {o1, o0};
    ifc.req_a       = {a1, a0};
    ifc.req_b       = {b1, b0};
    ifc.req_flag_we = we;
    ifc.resp_ready  = rr;
  endtask

  // One clock: check issue-side outputs, advance the model, check registers.
  task automatic step();
    bit          acc;
    int          g;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [17:0] r;
    #1;
    acc = 1'b0;
    g   = 0;
    if (!rst && (!m_rv || ifc.resp_ready) && ifc.req_valid != 2'b00) begin
      acc = 1'b1;
      if (ifc.req_valid == 2'b11) g = FIXED ? 0 : 1 - m_last;
      else                        g = ifc.req_valid[1] ? 1 : 0;
    end
    op = (g == 1) ? ifc.req_op[5:3] : ifc.req_op[2:0];
    a  = (g == 1) ? ifc.req_a[31:16] : ifc.req_a[15:0];
    b  = (g == 1) ? ifc.req_b[31:16] : ifc.req_b[15:0];
    chk("req_ready", ifc.req_ready, acc ? 2'(1 << g) : 2'b00);
    chk("alu_sigs", ifc.alu_sigs, acc ? exp_sigs(op) : 4'b0000);
    chk("alu_a", ifc.alu_a, a);
    chk("alu_b", ifc.alu_b, b);

    if (rst) begin
      m_rv = 0; m_id = 0; m_data = '0; m_err = 0;
      m_z = 0; m_v = 0; m_n = 0; m_last = 1;
    end else if (acc) begin
      r      = ref_op(op, a, b);
      m_rv   = 1'b1;
      m_id   = (g == 1);
      m_err  = r[17];
      m_data = r[17] ? 16'h0000 : r[15:0];
      if (ifc.req_flag_we[g] && !r[17]) begin
        m_z = (r[15:0] == 16'h0000);
        if (op == 3'd0 || op == 3'd1) begin
          m_n = r[15];
          m_v = r[16];
        end
      end
      m_last = g;
    end else if (ifc.resp_ready) begin
      m_rv = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", ifc.resp_valid, m_rv);
    chk("resp_id",    ifc.resp_id,    m_id);
    chk("resp_data",  ifc.resp_data,  m_data);
    chk("resp_err",   ifc.resp_err,   m_err);
    chk("flag_z",     ifc.flag_z,     m_z);
    chk("flag_v",     ifc.flag_v,     m_v);
    chk("flag_n",     ifc.flag_n,     m_n);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    m_rv = 0; m_id = 0; m_data = '0; m_err = 0;
    m_z = 0; m_v = 0; m_n = 0; m_last = 1;
    drive(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);

    // reset
    rst = 1'b1;
    step();
    step();
    chk("reset_resp_valid", ifc.resp_valid, 1'b0);
    rst = 1'b0;

    // r0 ADD saturating
    drive(2'b01, 3'd0, 3'd0, 16'h0, 16'h7FFF, 16'h0, 16'h0001, 2'b11, 1'b1);
    step();
    chk("add_sat_data", ifc.resp_data, 16'h7FFF);
    chk("add_sat_v",    ifc.flag_v,    1'b1);

    // r1 SUB to zero
    drive(2'b10, 3'd1, 3'd0, 16'h0005, 16'h0, 16'h0005, 16'h0, 2'b11, 1'b1);
    step();
    chk("sub_zero_z",  ifc.flag_z,  1'b1);
    chk("sub_zero_id", ifc.resp_id, 1'b1);

    // r0 ADD negative saturation sets N and V, then NAND must keep them
    drive(2'b01, 3'd0, 3'd0, 16'h0, 16'h8000, 16'h0, 16'hFFFF, 2'b11, 1'b1);
    step();
    drive(2'b01, 3'd0, 3'd3, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 2'b11, 1'b1);
    step();
    chk("nand_data",   ifc.resp_data, 16'h0000);
    chk("nand_keep_n", ifc.flag_n,    1'b1);
    chk("nand_keep_v", ifc.flag_v,    1'b1);

    // r1 XOR without flag write so requester 1 holds last grant
    drive(2'b10, 3'd4, 3'd0, 16'h00F0, 16'h0, 16'h0FF0, 16'h0, 2'b00, 1'b1);
    step();

    // contention with free-flowing consumer
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 3'd2, 3'd0, 16'h7F01 + 16'(i), 16'h1234, 16'h0101, 16'h4321, 2'b11, 1'b1);
      step();
    end

    // backpressure then release
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 3'd3, 3'd1, 16'hAAAA, 16'h1000, 16'h5555, 16'h0001, 2'b11, 1'b0);
      step();
    end
    drive(2'b11, 3'd3, 3'd1, 16'hAAAA, 16'h1000, 16'h5555, 16'h0001, 2'b11, 1'b1);
    step();

    // illegal opcode
    drive(2'b01, 3'd0, 3'd7, 16'h0, 16'h1234, 16'h0, 16'h1234, 2'b11, 1'b1);
    step();
    chk("illegal_err",  ifc.resp_err,  1'b1);
    chk("illegal_data", ifc.resp_data, 16'h0000);

    // reset with a response pending
    drive(2'b11, 3'd0, 3'd0, 16'h1, 16'h1, 16'h1, 16'h1, 2'b11, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", ifc.resp_valid, 1'b0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            rnd16(), rnd16(), rnd16(), rnd16(),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters:
  - requester 0: pipeline EX stage;
  - requester 1: multi-cycle helper unit.
- Arbitrates requests round-robin and decodes the 3-bit opcode into the ALU's 4-bit Sigs control.
- Captures the ALU result into a one-entry response register with valid/ready backpressure.
- Owns the architectural Z/V/N flag register. The ALU's own N/V outputs are never relied on to hold state.

Parameters:
- NB, 16, datapath width. All data ports scale with it.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 2, per-requester request valid.
- req_ready, output, 2, per-requester grant; the handshake completes when valid&ready.
- req_op, input, 6, 3-bit opcode per requester ({op1,op0}).
- req_a, input, 2*NB, operand A per requester.
- req_b, input, 2*NB, operand B per requester.
- req_flag_we, input, 2, when set, the accepted op may update the flags.
- alu_a, output, NB, operand A to the ALU.
- alu_b, output, NB, operand B to the ALU.
- alu_sigs, output, 4, ALU control {s3,s2,s1,s0}.
- alu_out, input, NB, ALU result.
- alu_v, input, 1, ALU overflow.
- alu_n, input, 1, ALU negative.
- alu_z, input, 1, ALU zero.
- resp_valid, output, 1, response register holds a result.
- resp_ready, input, 1, consumer accepts the response.
- resp_id, output, 1, requester index of the response.
- resp_data, output, NB, captured result.
- resp_err, output, 1, illegal opcode was issued.
- flag_z, output, 1, zero flag.
- flag_v, output, 1, overflow flag.
- flag_n, output, 1, negative flag.

Behaviour:
- Opcode to alu_sigs (s3 s2 s1 s0):
  - ADD=000 → 0100
  - SUB=001 → 0101
  - PADDSB=010 → 0110
  - NAND=011 → 1000
  - XOR=100 → 0000
  - 101-111 are illegal and drive sigs 0000.
- Accept condition: can_accept = !resp_valid | resp_ready.
  - req_ready[i] is asserted only for the granted requester, and only when can_accept=1 and req_valid[i]=1.
  - req_ready never asserts without req_valid.
- Arbitration:
  - last_grant register resets to 1, so requester 0 wins the first contention.
  - When both requesters are valid, grant the one that is not last_grant.
  - When one is valid, grant it.
  - last_grant updates only on an accepted transfer.
- Issue (combinational, same cycle as the grant):
  - alu_a, alu_b and alu_sigs mux from the granted requester.
  - When nothing is granted, they are driven from requester 0 with sigs 0000.
- Capture at the clock edge of acceptance:
  - resp_valid<=1;
  - resp_id<=grant;
  - resp_data<=alu_out (0 if illegal);
  - resp_err<=illegal.
  - Latency: 1 cycle, request handshake to resp_valid.
  - Throughput: 1 op/cycle while resp_ready=1.
- Response hold:
  - With resp_valid=1 and resp_ready=0, the response register holds and no grants issue.
  - With resp_valid=1 and resp_ready=1 and a new grant in the same cycle, the register is overwritten (drain and refill).
  - With resp_ready=1 and no grant, resp_valid<=0.
- Flags, updated at the capture edge only when req_flag_we[grant]=1 and the op is legal:
  - flag_z<=alu_z for all legal ops.
  - flag_n<=alu_n and flag_v<=alu_v for ADD/SUB only.
  - For PADDSB, NAND and XOR, N/V hold.
  - Illegal ops leave all flags unchanged.
- Reset (synchronous, rst=1), including mid-transfer:
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0;
  - flag_z=flag_v=flag_n=0;
  - last_grant=1; req_ready=0.
  - An in-flight response is discarded.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: strict priority to requester 0. last_grant is removed; requester 1 is granted only when req_valid[0]=0.
  - Undefined: round-robin as above.

Decomposition:
- alu_ctrl_pkg:
  - opcode enum (OP_ADD..OP_XOR);
  - SIGS_* 4-bit constants;
  - a decode function op→{sigs, illegal, sets_nv}.
- One natural sub-module: rr_arb2 (2-way round-robin grant with last_grant state, update-on-accept input).
- Flag register and response register stay in the top-level block.

Test Plan:
- r0 ADD a=0x7FFF b=0x0001 we=1 → next cycle resp_data=0x7FFF (saturated), resp_id=0, flag_v=1, flag_n=0, flag_z=0.
- r1 SUB a=0x0005 b=0x0005 we=1 → resp_data=0x0000, flag_z=1, flag_n=0, flag_v=0.
- After the SUB, r0 NAND a=0xFFFF b=0xFFFF we=1 → resp_data=0x0000, flag_z=1, flag_v/flag_n unchanged from the prior op.
- Both requesters valid for 4 cycles with resp_ready=1 → grants alternate 0,1,0,1; with the macro defined → 0,0,0,0.
- resp_ready=0 for 3 cycles with both requesters valid → resp_valid, resp_data and resp_id stable, req_ready=00. Release → drain and refill the same cycle.
- req_op=111 we=1 → resp_err=1, resp_data=0, flags unchanged. rst=1 while resp_valid=1 → next cycle resp_valid=0 and all flags 0.
